// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: the operation bus of seq_chunk_adder.
//   master : drives start, a, b, c_in and sub. It receives busy, done, sum, carry, c_out and ovf.
//   slave  : the adder side, with the same signals in the opposite directions.
// WIDTH is the operand and sum width in bits.
// CHUNK is the number of bits added per clock.
// carry is NCH = WIDTH/CHUNK bits wide. Bit i is the carry-out of chunk i.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
);
  localparam int unsigned NCH = WIDTH / CHUNK;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic [NCH-1:0]   carry;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, sum, carry, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, sum, carry, c_out, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: a sequential adder/subtractor that processes CHUNK bits per clock.
//   clk   : the single clock. All state changes on its rising edge.
//   rst_n : asynchronous, active-low reset.
//   bus   : a seq_chunk_adder_if slave.
//           start launches an operation on a, b, c_in and sub.
//           busy is high while chunks are being added.
//           done pulses for one cycle when the result is complete.
//           sum, carry (per-chunk carry-outs), c_out and ovf hold until the next accepted start.
// sub=0 computes A+B+c_in. sub=1 computes A-B as A + ~B + 1.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic            clk,
  input logic            rst_n,
  seq_chunk_adder_if.slave bus
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;     // B already inverted for subtraction
  logic             chain_c;  // carry into the chunk currently being added
  logic [WIDTH-1:0] sum_q;
  logic [NCH-1:0]   carry_q;
  logic             ovf_q;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             co_ch;
  logic             cmsb;
  logic             last;

  // Select the active chunk and add it.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (idx == IW'(j)) begin
        a_ch = a_q[j*CHUNK +: CHUNK];
        b_ch = bx_q[j*CHUNK +: CHUNK];
      end
    end
    {co_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, chain_c};
    // The carry into the chunk MSB is recovered from the XOR of that bit's addends and its sum bit.
    cmsb = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
    last = (idx == IW'(NCH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      bx_q    <= '0;
      chain_c <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            // sub is absorbed at capture time:
            //   B is stored inverted.
            //   The chunk-0 carry-in becomes 1.
            // This is why no separate mode register is kept.
            a_q     <= bus.a;
            bx_q    <= bus.sub ? ~bus.b : bus.b;
            chain_c <= bus.sub | bus.c_in;
            sum_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            idx     <= '0;
            state   <= RUN;
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          for (int unsigned j = 0; j < NCH; j++) begin
            if (idx == IW'(j)) begin
              sum_q[j*CHUNK +: CHUNK] <= s_ch;
              carry_q[j]              <= co_ch;
            end
          end
          chain_c <= co_ch;
          if (last) begin
            ovf_q <= cmsb ^ co_ch;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
  assign bus.c_out = carry_q[NCH-1];
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: a bench for seq_chunk_adder with two instances.
//   dut0 (WIDTH=16, CHUNK=4) is checked every cycle against an arithmetic model.
//   dut0 also gets literal checks on the directed scenarios.
//   dut1 (WIDTH=4, CHUNK=1) is swept over all {a,b,c_in} combinations in add mode.
`timescale 1ns/1ps
module tb_seq_chunk_adder;

  localparam int unsigned W0 = 16;
  localparam int unsigned C0 = 4;
  localparam int unsigned N0 = W0 / C0;
  localparam int unsigned W1 = 4;
  localparam int unsigned C1 = 1;
  localparam int unsigned N1 = W1 / C1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(W0), .CHUNK(C0)) bus0 ();
  seq_chunk_adder_if #(.WIDTH(W1), .CHUNK(C1)) bus1 ();

  seq_chunk_adder #(.WIDTH(W0), .CHUNK(C0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  seq_chunk_adder #(.WIDTH(W1), .CHUNK(C1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] lowmask(input int unsigned n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // ---------------- arithmetic model for dut0 ----------------
  typedef struct packed {
    logic [W0-1:0] s;
    logic [N0-1:0] c;
    logic          o;
  } res_t;

  function automatic res_t model_op(input logic [W0-1:0] ta, input logic [W0-1:0] tb_v,
                                    input logic tc, input logic ts);
    res_t r;
    logic [W0-1:0] bq;
    longint unsigned ci, m, part;
    longint sa, sb, sr, lim;
    bq = ts ? ~tb_v : tb_v;
    ci = (ts || tc) ? 64'd1 : 64'd0;
    r.c = '0;
    // The carry out of chunk i is the carry out of the low (i+1)*CHUNK bits of the whole addition.
    for (int i = 0; i < int'(N0); i++) begin
      m = 64'd1 << ((i + 1) * int'(C0));
      part = (64'(ta) % m) + (64'(bq) % m) + ci;
      r.c[i] = (part >= m);
    end
    part = 64'(ta) + 64'(bq) + ci;
    r.s = W0'(part);
    sa  = longint'($signed(ta));
    sb  = longint'($signed(tb_v));
    sr  = ts ? (sa - sb) : (sa + sb + longint'(ci));
    lim = longint'(1) <<< (W0 - 1);
    r.o = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  logic        m_active = 1'b0;
  logic        m_pulse  = 1'b0;
  int unsigned m_steps  = 0;
  res_t        f_res    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_pulse  <= 1'b0;
      m_steps  <= 0;
      f_res    <= '0;
    end else if (m_active) begin
      if (m_steps == N0 - 1) begin
        m_active <= 1'b0;
        m_pulse  <= 1'b1;
      end
      m_steps <= m_steps + 1;
    end else begin
      m_pulse <= 1'b0;
      if (bus0.start) begin
        f_res    <= model_op(bus0.a, bus0.b, bus0.c_in, bus0.sub);
        m_active <= 1'b1;
        m_steps  <= 0;
      end
    end
  end

  // While running, only the chunks already added are visible. The rest read as zero.
  always @(negedge clk) begin
    chk("busy",  64'(bus0.busy),  64'(m_active));
    chk("done",  64'(bus0.done),  64'(m_pulse));
    chk("sum",   64'(bus0.sum),   m_active ? (64'(f_res.s) & lowmask(m_steps * C0)) : 64'(f_res.s));
    chk("carry", 64'(bus0.carry), m_active ? (64'(f_res.c) & lowmask(m_steps)) : 64'(f_res.c));
    chk("c_out", 64'(bus0.c_out), m_active ? 64'd0 : 64'(f_res.c[N0-1]));
    chk("ovf",   64'(bus0.ovf),   m_active ? 64'd0 : 64'(f_res.o));
  end

  // ---------------- drivers ----------------
  task automatic wait_done0(output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus0.done === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  // Operands are scrambled right after acceptance. Any late input leak then shows up in the result.
  task automatic run_op(input logic [W0-1:0] ta, input logic [W0-1:0] tb_v,
                        input logic tc, input logic ts, output int lat);
    @(posedge clk); #2;
    bus0.a = ta; bus0.b = tb_v; bus0.c_in = tc; bus0.sub = ts; bus0.start = 1'b1;
    @(posedge clk); #2;
    bus0.start = 1'b0; bus0.a = ~ta; bus0.b = ~tb_v; bus0.c_in = ~tc; bus0.sub = ~ts;
    wait_done0(lat);
  endtask

  task automatic chk_final(input string nm, input logic [W0-1:0] es, input logic [N0-1:0] ec,
                           input logic eco, input logic eov, input int lat);
    chk({nm, "_lat"},   64'(lat),        64'(N0 + 1));
    chk({nm, "_sum"},   64'(bus0.sum),   64'(es));
    chk({nm, "_carry"}, 64'(bus0.carry), 64'(ec));
    chk({nm, "_c_out"}, 64'(bus0.c_out), 64'(eco));
    chk({nm, "_ovf"},   64'(bus0.ovf),   64'(eov));
  endtask

  initial begin
    int lat;
    int pulses;
    int t1;
    int t2;
    logic [W0-1:0] seen_sum;
    logic [W1-1:0] xa, xb;
    logic          xc;
    logic [W1:0]   exp5;

    bus0.start = 1'b0; bus0.a = '0; bus0.b = '0; bus0.c_in = 1'b0; bus0.sub = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0; bus1.sub = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy",  64'(bus0.busy),  64'd0);
    chk("rst_done",  64'(bus0.done),  64'd0);
    chk("rst_sum",   64'(bus0.sum),   64'd0);
    chk("rst_carry", 64'(bus0.carry), 64'd0);
    chk("rst_c_out", 64'(bus0.c_out), 64'd0);
    chk("rst_ovf",   64'(bus0.ovf),   64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Add with full carry ripple.
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    chk_final("add_ffff", 16'h0000, 4'b1111, 1'b1, 1'b0, lat);

    // Subtract with signed overflow.
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    chk_final("sub_8000", 16'h7FFF, 4'b1000, 1'b1, 1'b1, lat);

    // Subtract with a borrow.
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, lat);
    chk_final("sub_3_5", 16'hFFFE, 4'b0000, 1'b0, 1'b0, lat);

    // Add with carry-in set, giving signed overflow.
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, lat);
    chk_final("add_cin", 16'h8000, 4'b0111, 1'b0, 1'b1, lat);

    // c_in must be ignored in subtract mode.
    run_op(16'h0010, 16'h0001, 1'b1, 1'b1, lat);
    chk_final("sub_cin", 16'h000F, 4'b1110, 1'b1, 1'b0, lat);

    // Extra patterns, checked only by the per-cycle model.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, lat);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, lat);

    // A start pulse during RUN must be ignored.
    @(posedge clk); #2;
    bus0.a = 16'h1000; bus0.b = 16'h0200; bus0.c_in = 1'b0; bus0.sub = 1'b0; bus0.start = 1'b1;
    @(posedge clk); #2;
    bus0.start = 1'b0; bus0.a = 16'hFFFF;
    @(posedge clk); #2;
    bus0.start = 1'b1; bus0.a = 16'h5555; bus0.b = 16'h5555; bus0.sub = 1'b1;
    @(posedge clk); #2;
    bus0.start = 1'b0;
    pulses = 0;
    seen_sum = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus0.done === 1'b1) begin
        pulses++;
        seen_sum = bus0.sum;
      end
    end
    chk("ign_pulses", 64'(pulses), 64'd1);
    chk("ign_sum",    64'(seen_sum), 64'h1200);

    // Reset while RUN is at index 2.
    @(posedge clk); #2;
    bus0.a = 16'hABCD; bus0.b = 16'h1111; bus0.c_in = 1'b0; bus0.sub = 1'b0; bus0.start = 1'b1;
    @(posedge clk); #2;
    bus0.start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  64'(bus0.busy),  64'd0);
    chk("abort_done",  64'(bus0.done),  64'd0);
    chk("abort_sum",   64'(bus0.sum),   64'd0);
    chk("abort_carry", 64'(bus0.carry), 64'd0);
    chk("abort_c_out", 64'(bus0.c_out), 64'd0);
    chk("abort_ovf",   64'(bus0.ovf),   64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus0.done === 1'b1) pulses++;
    end
    chk("abort_nodone", 64'(pulses), 64'd0);
    run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, lat);
    chk_final("post_rst", 16'h1010, 4'b0101, 1'b0, 1'b0, lat);

    // Back-to-back operations with start held high across DONE.
    @(posedge clk); #2;
    bus0.a = 16'h1234; bus0.b = 16'h1111; bus0.c_in = 1'b0; bus0.sub = 1'b0; bus0.start = 1'b1;
    @(posedge clk); #2;
    wait_done0(lat);
    t1 = cyc;
    chk_final("b2b_1", 16'h2345, 4'b0000, 1'b0, 1'b0, lat);
    bus0.a = 16'h00FF; bus0.b = 16'h0001;
    @(posedge clk); #2;
    bus0.start = 1'b0;
    wait_done0(lat);
    t2 = cyc;
    chk_final("b2b_2", 16'h0100, 4'b0011, 1'b0, 1'b0, lat);
    chk("b2b_spacing", 64'(t2 - t1), 64'(N0 + 1));

    // Exhaustive sweep of the single-bit-chunk instance in add mode.
    for (int i = 0; i < 512; i++) begin
      xc = i[0];
      xb = i[4:1];
      xa = i[8:5];
      exp5 = {1'b0, xa} + {1'b0, xb} + {{W1{1'b0}}, xc};
      @(posedge clk); #2;
      bus1.a = xa; bus1.b = xb; bus1.c_in = xc; bus1.sub = 1'b0; bus1.start = 1'b1;
      @(posedge clk); #2;
      bus1.start = 1'b0; bus1.a = ~xa; bus1.b = ~xb; bus1.c_in = ~xc;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (bus1.done === 1'b1) begin
          lat = k;
          break;
        end
      end
      chk("x_lat", 64'(lat), 64'(N1 + 1));
      chk("x_sum", 64'({bus1.c_out, bus1.sum}), 64'(exp5));
    end

    @(posedge clk); #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
